// File: rtl/das_beamformer_core_if.sv
// Pin-side bus of the delay-and-sum beamformer: mic data, word select, MCU config port, sum outputs.
// Latency: none (wiring only).
// Backpressure: none; every stream free-runs at the bit clock.
interface das_beamformer_core_if #(
   parameter int NUM_MICS    = 4,
   parameter int SAMPLE_BITS = 16,
   parameter int DEPTH       = 16
);
   localparam int NCH   = 2 * NUM_MICS;
   localparam int CW    = $clog2(NCH);
   localparam int DW    = $clog2(DEPTH);
   localparam int SUM_W = SAMPLE_BITS + CW;

   // mic side
   logic [NUM_MICS-1:0] data_in;
   logic                ws_out;
   // MCU configuration port
   logic                cfg_we;
   logic [CW-1:0]       cfg_sel;
   logic [DW-1:0]       cfg_delay;
   logic                cfg_en;
   // beamformed output
   logic [SUM_W-1:0]    sum_out;
   logic                sum_valid;
   logic                sdo;

   modport master (
      output data_in, cfg_we, cfg_sel, cfg_delay, cfg_en,
      input  ws_out, sum_out, sum_valid, sdo
   );

   modport slave (
      input  data_in, cfg_we, cfg_sel, cfg_delay, cfg_en,
      output ws_out, sum_out, sum_valid, sdo
   );
endinterface

// File: rtl/das_beamformer_core.sv
// Delay-and-sum beamformer: I2S capture of 2*NUM_MICS channels, per-channel delayed taps, signed sum.
// Latency: a sample captured in frame n with tap delay d is summed in the pulse of frame n+1+d.
// Backpressure: none; the block is paced by the bit clock and always accepts data and config.
module das_beamformer_core #(
   parameter int NUM_MICS    = 4,
   parameter int SAMPLE_BITS = 16,
   parameter int SLOT_BITS   = 32,
   parameter int DEPTH       = 16
) (
   input logic                  clk,
   input logic                  reset,
   das_beamformer_core_if.slave bus
);
   localparam int NCH   = 2 * NUM_MICS;
   localparam int DW    = $clog2(DEPTH);
   localparam int CW    = $clog2(NCH);
   localparam int SUM_W = SAMPLE_BITS + CW;
   localparam int FRAME = 2 * SLOT_BITS;
   localparam int CNTW  = $clog2(FRAME);

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAME - 1);
   localparam logic [CNTW-1:0] CAP_L_LO = CNTW'(1);
   localparam logic [CNTW-1:0] CAP_L_HI = CNTW'(SAMPLE_BITS);
   localparam logic [CNTW-1:0] CAP_R_LO = CNTW'(SLOT_BITS + 1);
   localparam logic [CNTW-1:0] CAP_R_HI = CNTW'(SLOT_BITS + SAMPLE_BITS);
   localparam logic [CNTW-1:0] WS_HI    = CNTW'(SLOT_BITS);
   localparam logic [CW:0]     NCH_C    = (CW + 1)'(NCH);

   // frame timing
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_nxt;
   logic            ws_r;
   logic            push;
   logic            sum_ld;
   logic            cap_l;
   logic            cap_r;

   // capture shift registers, one pair per mic line
   logic [NUM_MICS-1:0][SAMPLE_BITS-1:0] sh_l;
   logic [NUM_MICS-1:0][SAMPLE_BITS-1:0] sh_r;

   // per-channel circular sample buffers
   logic [NCH-1:0][DEPTH-1:0][SAMPLE_BITS-1:0] smp_mem;
   logic [DW-1:0]                              wr_ptr;

   // configuration: shadow written by the MCU, active used by the taps
   logic [NCH-1:0][DW-1:0] shd_dly;
   logic [NCH-1:0][DW-1:0] shd_dly_nxt;
   logic [NCH-1:0][DW-1:0] act_dly;
   logic [NCH-1:0]         shd_en;
   logic [NCH-1:0]         shd_en_nxt;
   logic [NCH-1:0]         act_en;
   logic                   sel_ok;

   // sum path
   logic [SUM_W-1:0]       tap_sum;
   logic [DW-1:0]          rd_addr;
   logic [SAMPLE_BITS-1:0] tap;
   logic [SUM_W-1:0]       sum_r;
   logic                   sum_vld_r;
   logic [SUM_W-1:0]       osr;

   assign push    = (cnt == CNT_LAST);
   assign sum_ld  = (cnt == '0);
   assign cnt_nxt = push ? '0 : cnt + CNTW'(1);
   // I2S: the MSB arrives one bit clock after the word-select change
   assign cap_l   = (cnt >= CAP_L_LO) && (cnt <= CAP_L_HI);
   assign cap_r   = (cnt >= CAP_R_LO) && (cnt <= CAP_R_HI);

   // Frame counter; ws is computed from the next count so it lines up with cnt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         ws_r <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         ws_r <= (cnt_nxt >= WS_HI);
      end
   end

   assign bus.ws_out = ws_r;

   // Deserialise left and right slots MSB first; other bit positions are ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_l <= '0;
         sh_r <= '0;
      end else begin
         for (int m = 0; m < NUM_MICS; m++) begin
            if (cap_l) sh_l[m] <= {sh_l[m][SAMPLE_BITS-2:0], bus.data_in[m]};
            if (cap_r) sh_r[m] <= {sh_r[m][SAMPLE_BITS-2:0], bus.data_in[m]};
         end
      end
   end

   // Channel indices beyond NCH (non power-of-two mic counts) are dropped.
   assign sel_ok = ({1'b0, bus.cfg_sel} < NCH_C);

   // Shadow view including this cycle's write, so a write on the push edge is transferred.
   always_comb begin
      shd_dly_nxt = shd_dly;
      shd_en_nxt  = shd_en;
      if (bus.cfg_we && sel_ok) begin
         shd_dly_nxt[bus.cfg_sel] = bus.cfg_delay;
         shd_en_nxt[bus.cfg_sel]  = bus.cfg_en;
      end
   end

   // Shadow follows the MCU; active copies only on the push edge to keep frames glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shd_dly <= '0;
         shd_en  <= '1;
         act_dly <= '0;
         act_en  <= '1;
      end else begin
         shd_dly <= shd_dly_nxt;
         shd_en  <= shd_en_nxt;
         if (push) begin
            act_dly <= shd_dly_nxt;
            act_en  <= shd_en_nxt;
         end
      end
   end

   // At frame end every channel stores its captured sample and the write pointer advances.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         smp_mem <= '0;
         wr_ptr  <= '0;
      end else if (push) begin
         for (int m = 0; m < NUM_MICS; m++) begin
            smp_mem[2*m][wr_ptr]   <= sh_l[m];
            smp_mem[2*m+1][wr_ptr] <= sh_r[m];
         end
         wr_ptr <= wr_ptr + DW'(1);
      end
   end

   // Delayed taps: delay 0 is the newest pushed entry; SUM_W bits cannot overflow.
   always_comb begin
      tap_sum = '0;
      rd_addr = '0;
      tap     = '0;
      for (int c = 0; c < NCH; c++) begin
         rd_addr = wr_ptr - DW'(1) - act_dly[c];
         tap     = smp_mem[c][rd_addr];
         if (act_en[c]) tap_sum = tap_sum + {{CW{tap[SAMPLE_BITS-1]}}, tap};
      end
   end

   // Sum registers at cnt 0; the serial copy then shifts out MSB first and flushes to zeros
   // well before the right slot since SLOT_BITS exceeds SUM_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_r     <= '0;
         sum_vld_r <= 1'b0;
         osr       <= '0;
      end else begin
         sum_vld_r <= sum_ld;
         if (sum_ld) begin
            sum_r <= tap_sum;
            osr   <= tap_sum;
         end else begin
            osr <= {osr[SUM_W-2:0], 1'b0};
         end
      end
   end

   assign bus.sum_out   = sum_r;
   assign bus.sum_valid = sum_vld_r;
   assign bus.sdo       = osr[SUM_W-1];
endmodule

// File: tb/tb_das_beamformer_core.sv
// Bench for das_beamformer_core: drives I2S mic data and config, scores sum/sdo/ws against a frame model.
// Latency: expected sums are queued at each frame push and popped at the following cnt=1 pulse.
// Backpressure: none; stimulus is clocked every bit clock.
module tb_das_beamformer_core;
   localparam int NUM_MICS    = 4;
   localparam int SAMPLE_BITS = 16;
   localparam int SLOT_BITS   = 32;
   localparam int DEPTH       = 16;
   localparam int NCH         = 2 * NUM_MICS;
   localparam int CW          = 3;
   localparam int DW          = 4;
   localparam int SUM_W       = SAMPLE_BITS + CW;
   localparam int FRAME       = 2 * SLOT_BITS;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   das_beamformer_core_if #(.NUM_MICS(NUM_MICS), .SAMPLE_BITS(SAMPLE_BITS), .DEPTH(DEPTH)) bif ();

   das_beamformer_core #(
      .NUM_MICS(NUM_MICS), .SAMPLE_BITS(SAMPLE_BITS), .SLOT_BITS(SLOT_BITS), .DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int at;
      int sel;
      int dly;
      bit en;
   } cfg_op_t;

   typedef struct {
      logic [NCH-1:0][SAMPLE_BITS-1:0] smp;
      logic [NCH-1:0]                  en;
      logic [SUM_W-1:0]                want;
   } vec_t;

   cfg_op_t          cfg_q[$];
   logic [SUM_W-1:0] exp_q[$];
   logic [SUM_W-1:0] pulse_log[$];

   logic [SAMPLE_BITS-1:0] smp  [NCH];
   logic [SAMPLE_BITS-1:0] hist [NCH][DEPTH];
   int                     sh_dly [NCH];
   int                     act_dly[NCH];
   bit                     sh_en  [NCH];
   bit                     act_en [NCH];
   int                     tcnt;
   logic [SUM_W-1:0]       cur_exp;
   int                     errors = 0;
   int                     checks = 0;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cnt=%0d, t=%0t)", name, act, want, tcnt, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < DEPTH; k++) hist[c][k] = '0;
         sh_dly[c]  = 0;
         act_dly[c] = 0;
         sh_en[c]   = 1'b1;
         act_en[c]  = 1'b1;
      end
      exp_q.delete();
      exp_q.push_back('0);
      cfg_q.delete();
      cur_exp = '0;
      tcnt    = 0;
   endtask

   // Age-indexed history: hist[c][0] is the most recently pushed frame.
   task automatic model_push();
      int          s;
      logic [31:0] sv;
      s = 0;
      for (int c = 0; c < NCH; c++) begin
         for (int k = DEPTH - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
         hist[c][0] = smp[c];
         act_dly[c] = sh_dly[c];
         act_en[c]  = sh_en[c];
      end
      for (int c = 0; c < NCH; c++)
         if (act_en[c]) s += int'($signed(hist[c][act_dly[c]]));
      sv = s;
      exp_q.push_back(sv[SUM_W-1:0]);
   endtask

   // One bit clock: check outputs for the current count, drive inputs for the coming edge.
   task automatic tick();
      cfg_op_t op;
      bit      sdo_e;
      check("ws_out", bif.ws_out, tcnt >= SLOT_BITS);
      if (tcnt == 1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got a pulse, want a queued expectation (t=%0t)", $time);
         end else begin
            cur_exp = exp_q.pop_front();
            check("sum_out", bif.sum_out, cur_exp);
         end
         check("sum_valid_hi", bif.sum_valid, 1);
         pulse_log.push_back(bif.sum_out);
      end else begin
         check("sum_valid_lo", bif.sum_valid, 0);
      end
      sdo_e = (tcnt >= 1 && tcnt <= SUM_W) ? cur_exp[SUM_W-tcnt] : 1'b0;
      check("sdo", bif.sdo, sdo_e);

      bif.cfg_we = 1'b0;
      if (cfg_q.size() > 0 && cfg_q[0].at == tcnt) begin
         op            = cfg_q.pop_front();
         bif.cfg_we    = 1'b1;
         bif.cfg_sel   = op.sel[CW-1:0];
         bif.cfg_delay = op.dly[DW-1:0];
         bif.cfg_en    = op.en;
         sh_dly[op.sel] = op.dly;
         sh_en[op.sel]  = op.en;
      end
      for (int m = 0; m < NUM_MICS; m++) begin
         if (tcnt >= 1 && tcnt <= SAMPLE_BITS)
            bif.data_in[m] = smp[2*m][SAMPLE_BITS-tcnt];
         else if (tcnt >= SLOT_BITS + 1 && tcnt <= SLOT_BITS + SAMPLE_BITS)
            bif.data_in[m] = smp[2*m+1][SAMPLE_BITS-(tcnt-SLOT_BITS)];
         else
            bif.data_in[m] = 1'($urandom_range(0, 1));
      end
      if (tcnt == FRAME - 1) model_push();
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % FRAME;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_frames(input int n);
      run_ticks(n * FRAME);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ws"},  bif.ws_out,    0);
      check({tag, "_sum"}, bif.sum_out,   0);
      check({tag, "_vld"}, bif.sum_valid, 0);
      check({tag, "_sdo"}, bif.sdo,       0);
   endtask

   initial begin
      logic [SAMPLE_BITS-1:0] v5[7];
      logic [SUM_W-1:0]       w5[7];
      vec_t                   v;

      vecs[0] = '{smp: {8{16'h8000}}, en: 8'hFF, want: 19'h40000};
      vecs[1] = '{smp: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h0},
                  en: 8'b1111_1011, want: 19'h00100};
      vecs[2] = '{smp: {8{16'h7FFF}}, en: 8'hFF, want: 19'h3FFF8};
      vecs[3] = '{smp: {16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'hFFFF, 16'h0001},
                  en: 8'hFF, want: 19'h01234};
      vecs[4] = '{smp: {8{16'hFFFF}}, en: 8'h0F, want: 19'h7FFFC};
      vecs[5] = '{smp: {8{16'h1000}}, en: 8'h00, want: 19'h00000};
      vecs[6] = '{smp: {16'h0707, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101, 16'h0000},
                  en: 8'hFF, want: 19'h01C1C};

      bif.data_in   = '0;
      bif.cfg_we    = 1'b0;
      bif.cfg_sel   = '0;
      bif.cfg_delay = '0;
      bif.cfg_en    = 1'b0;
      for (int c = 0; c < NCH; c++) smp[c] = '0;
      tcnt    = 0;
      cur_exp = '0;

      // reset state, then two free-running frames of silence
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("rst");
      reset = 1'b0;
      model_reset();
      run_frames(2);

      // steady-state sums, delays 0, enables from the table
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         for (int c = 0; c < NCH; c++) begin
            smp[c] = v.smp[c];
            cfg_q.push_back('{at: 10 + c, sel: c, dly: 0, en: v.en[c]});
         end
         run_frames(2);
         check($sformatf("vec%0d_sum", i), pulse_log[$], v.want);
      end

      // impulse on channel 0 through a delay of 3 frames, all other channels off
      for (int c = 0; c < NCH; c++) begin
         smp[c] = '0;
         cfg_q.push_back('{at: 10 + c, sel: c, dly: (c == 0) ? 3 : 0, en: (c == 0)});
      end
      run_frames(4);
      pulse_log.delete();
      smp[0] = 16'h1234;
      run_frames(1);
      smp[0] = '0;
      run_frames(6);
      for (int i = 0; i < 7; i++)
         check($sformatf("impulse_f%0d", i), pulse_log[i], (i == 4) ? 19'h01234 : 19'h0);

      // delay change 0 -> 2 mid-frame, then back to 0 with a write on the push edge
      cfg_q.push_back('{at: 10, sel: 0, dly: 0, en: 1'b1});
      run_frames(1);
      pulse_log.delete();
      for (int k = 0; k < 7; k++) v5[k] = 16'h0100 + 16'(k * 16'h0011);
      w5 = '{19'h0, {3'b0, v5[0]}, {3'b0, v5[1]}, {3'b0, v5[2]},
             {3'b0, v5[1]}, {3'b0, v5[2]}, {3'b0, v5[5]}};
      for (int k = 0; k < 7; k++) begin
         smp[0] = v5[k];
         if (k == 3) cfg_q.push_back('{at: 20, sel: 0, dly: 2, en: 1'b1});
         if (k == 5) cfg_q.push_back('{at: FRAME - 1, sel: 0, dly: 0, en: 1'b1});
         run_frames(1);
      end
      for (int k = 0; k < 7; k++)
         check($sformatf("dlychg_f%0d", k), pulse_log[k], w5[k]);

      // fill buffers with non-zero data, then reset mid-frame at cnt 40
      for (int c = 0; c < NCH; c++) smp[c] = 16'h0555;
      run_frames(2);
      run_ticks(40);
      reset = 1'b1;
      #1;
      check_outputs_zero("arst");
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("arst_hold");
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < NCH; c++) begin
         smp[c] = '0;
         cfg_q.push_back('{at: 10 + c, sel: c, dly: 2 * c + 1, en: 1'b1});
      end
      pulse_log.delete();
      run_frames(3);
      for (int i = 0; i < 3; i++)
         check($sformatf("post_rst_f%0d", i), pulse_log[i], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
